// File: rtl/hps_frame_read_ctrl.sv
// hps_frame_read_ctrl: sequences one still-frame capture, then serves packed
// 8-pixel words from the SDRAM read FIFO to the HPS, one word per step edge.
//
// Ports:
//   iCLK, iRST_N     controller clock, async active-low reset
//   iHPS_START       HPS start level (async, synchronised here)
//   iHPS_STEP        HPS step toggle, each edge requests a word (async)
//   iCCD_FVAL        camera frame-valid level (async)
//   iRD_DATA         read FIFO data, [7:0] holds 8 packed pixels
//   oCAPTURE_EN      CCD capture enable
//   oRD_LOAD         1-cycle FIFO read address reload
//   oRD_REQ          1-cycle FIFO read strobe
//   oPIX_BYTE        last latched packed pixels
//   oROW, oCOL       line / word column of oPIX_BYTE
//   oACK             toggles once per served word
//   oDONE            whole frame served, held until start drops
//   oOVERRUN         sticky, step edge seen while busy
//   oSTATE           state encoding for LEDs
module hps_frame_read_ctrl #(
    parameter int H_WORDS        = 80,
    parameter int V_LINES        = 480,
    parameter int CAPTURE_FRAMES = 1,
    parameter int RD_LAT         = 1
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iHPS_START,
    input  logic        iHPS_STEP,
    input  logic        iCCD_FVAL,
    input  logic [15:0] iRD_DATA,
    output logic        oCAPTURE_EN,
    output logic        oRD_LOAD,
    output logic        oRD_REQ,
    output logic [7:0]  oPIX_BYTE,
    output logic [8:0]  oROW,
    output logic [6:0]  oCOL,
    output logic        oACK,
    output logic        oDONE,
    output logic        oOVERRUN,
    output logic [2:0]  oSTATE
);

    localparam int FW = (CAPTURE_FRAMES < 2) ? 1 : $clog2(CAPTURE_FRAMES + 1);

    localparam logic [FW-1:0] FRAMES   = FW'(CAPTURE_FRAMES);
    localparam logic [8:0]    ROW_LAST = 9'(V_LINES - 1);
    localparam logic [6:0]    COL_LAST = 7'(H_WORDS - 1);
    localparam logic [1:0]    LAT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        WAIT_SOF = 3'd2,
        WAIT_EOF = 3'd3,
        SERVE    = 3'd4,
        FETCH    = 3'd5,
        LATCH    = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t state, state_nxt;

    logic [1:0]    start_sr;
    logic [2:0]    step_sr;
    logic [2:0]    fval_sr;
    logic [8:0]    row;
    logic [6:0]    col;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_nxt;
    logic [1:0]    fetch_cnt;

    logic start_on;
    logic step_edge;
    logic fval_rise;
    logic fval_fall;
    logic last_word;
    logic do_latch;
    logic frame_inc;

    // Upper FIFO byte carries no pixel data.
    logic unused_hi;
    assign unused_hi = ^iRD_DATA[15:8];

    assign start_on  = start_sr[1];
    assign step_edge = step_sr[1] ^ step_sr[2];
    assign fval_rise = fval_sr[1] & ~fval_sr[2];
    assign fval_fall = ~fval_sr[1] & fval_sr[2];
    assign last_word = (row == ROW_LAST) && (col == COL_LAST);
    assign frame_nxt = frame_cnt + 1'b1;
    assign do_latch  = (state == LATCH) && start_on;
    assign frame_inc = (state == WAIT_EOF) && start_on && fval_fall;
    assign oSTATE    = state;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Losing start overrides everything: strobes are suppressed in that
    // cycle so an abort never issues a read.
    always_comb begin
        state_nxt   = state;
        oRD_LOAD    = 1'b0;
        oRD_REQ     = 1'b0;
        oCAPTURE_EN = 1'b0;
        oDONE       = 1'b0;
        if (state != IDLE && !start_on) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_on) state_nxt = ARM;
                end
                ARM: begin
                    oRD_LOAD  = 1'b1;
                    state_nxt = WAIT_SOF;
                end
                WAIT_SOF: begin
                    oCAPTURE_EN = 1'b1;
                    if (fval_rise) state_nxt = WAIT_EOF;
                end
                WAIT_EOF: begin
                    oCAPTURE_EN = 1'b1;
                    if (fval_fall) begin
                        if (frame_nxt == FRAMES) state_nxt = SERVE;
                        else                     state_nxt = WAIT_SOF;
                    end
                end
                SERVE: begin
                    if (step_edge) state_nxt = FETCH;
                end
                FETCH: begin
                    oRD_REQ = (fetch_cnt == 2'd0);
                    if (fetch_cnt == LAT_LAST) state_nxt = LATCH;
                end
                LATCH: begin
                    state_nxt = last_word ? DONE : SERVE;
                end
                DONE: begin
                    oDONE = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            start_sr  <= '0;
            step_sr   <= '0;
            fval_sr   <= '0;
            row       <= '0;
            col       <= '0;
            frame_cnt <= '0;
            fetch_cnt <= '0;
            oPIX_BYTE <= '0;
            oROW      <= '0;
            oCOL      <= '0;
            oACK      <= 1'b0;
            oOVERRUN  <= 1'b0;
        end else begin
            start_sr <= {start_sr[0], iHPS_START};
            step_sr  <= {step_sr[1:0], iHPS_STEP};
            fval_sr  <= {fval_sr[1:0], iCCD_FVAL};

            fetch_cnt <= (state == FETCH) ? fetch_cnt + 2'd1 : 2'd0;

            if (state == ARM) begin
                row       <= '0;
                col       <= '0;
                frame_cnt <= '0;
                oOVERRUN  <= 1'b0;
            end

            if (frame_inc) frame_cnt <= frame_nxt;

            if (do_latch) begin
                oPIX_BYTE <= iRD_DATA[7:0];
                oROW      <= row;
                oCOL      <= col;
                oACK      <= ~oACK;
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row != ROW_LAST) row <= row + 9'd1;
                end else begin
                    col <= col + 7'd1;
                end
            end

            // A step edge outside SERVE is dropped, not queued.
            if (step_edge && !(state inside {IDLE, SERVE, DONE}))
                oOVERRUN <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hps_frame_read_ctrl.sv
// tb_hps_frame_read_ctrl: directed bench for hps_frame_read_ctrl with a
// small FIFO model; frame height reduced to 4 lines to keep runs short.
module tb_hps_frame_read_ctrl;

    localparam int H  = 80;
    localparam int V  = 4;
    localparam int LT = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        step;
    logic        fval;
    logic [15:0] rd_data;
    logic        cap_en;
    logic        rd_load;
    logic        rd_req;
    logic [7:0]  pix;
    logic [8:0]  row;
    logic [6:0]  col;
    logic        ack;
    logic        done;
    logic        overrun;
    logic [2:0]  state;

    int vectors = 0;
    int errors  = 0;
    int req_cnt = 0;
    int load_cnt = 0;

    hps_frame_read_ctrl #(
        .H_WORDS(H),
        .V_LINES(V),
        .CAPTURE_FRAMES(1),
        .RD_LAT(LT)
    ) dut (
        .iCLK(clk),
        .iRST_N(rst_n),
        .iHPS_START(start),
        .iHPS_STEP(step),
        .iCCD_FVAL(fval),
        .iRD_DATA(rd_data),
        .oCAPTURE_EN(cap_en),
        .oRD_LOAD(rd_load),
        .oRD_REQ(rd_req),
        .oPIX_BYTE(pix),
        .oROW(row),
        .oCOL(col),
        .oACK(ack),
        .oDONE(done),
        .oOVERRUN(overrun),
        .oSTATE(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: word k returns {k, A5+k} exactly LT cycles after its
    // strobe, garbage otherwise; a load rewinds to word 0.
    bit        v1, v2;
    bit [15:0] i1, i2;
    int        req_idx = 0;

    always @(posedge clk) begin
        v1 <= rd_req;
        v2 <= v1;
        i1 <= 16'(req_idx);
        i2 <= i1;
        if (rd_load)     req_idx <= 0;
        else if (rd_req) req_idx <= req_idx + 1;
        if (rd_req === 1'b1)  req_cnt  <= req_cnt + 1;
        if (rd_load === 1'b1) load_cnt <= load_cnt + 1;
    end

    assign rd_data = v2 ? {i2[7:0], 8'hA5 + i2[7:0]} : 16'hEE11;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s,
                              input int max);
        for (int i = 0; i < max; i++) begin
            if (state == s) break;
            @(negedge clk);
        end
        check(tag, state, s);
    endtask

    task automatic serve(input int n);
        logic       a0, a1;
        int         r0;
        logic [7:0] eb;
        logic [8:0] er;
        logic [6:0] ec;
        a0 = ack;
        a1 = ~a0;
        r0 = req_cnt;
        eb = 8'hA5 + n[7:0];
        er = 9'(n / H);
        ec = 7'(n % H);
        tick(1);
        step = ~step;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack !== a0) break;
        end
        check($sformatf("ack%0d", n), ack, a1);
        check($sformatf("pix%0d", n), pix, eb);
        check($sformatf("row%0d", n), row, er);
        check($sformatf("col%0d", n), col, ec);
        check($sformatf("req%0d", n), req_cnt - r0, 1);
    endtask

    initial begin
        int   r0, l0;
        logic a0, a1;

        rst_n = 1'b0;
        start = 1'b0;
        step  = 1'b0;
        fval  = 1'b0;
        tick(3);
        check("rst_state", state, 3'd0);
        check("rst_outs", {cap_en, rd_load, rd_req, ack, done, overrun},
              6'b0);
        check("rst_pix", {pix, row, col}, 24'h0);
        rst_n = 1'b1;
        tick(2);

        // Single frame capture.
        l0 = load_cnt;
        start = 1'b1;
        wait_state("arm_sof", 3'd2, 10);
        check("load1", load_cnt - l0, 1);
        check("cap_sof", cap_en, 1'b1);
        tick(3);
        fval = 1'b1;
        wait_state("eof", 3'd3, 10);
        check("cap_eof", cap_en, 1'b1);
        tick(5);
        fval = 1'b0;
        wait_state("serve", 3'd4, 10);
        check("cap_serve", cap_en, 1'b0);

        // Whole frame: row wrap at word 80, done after the last word.
        for (int n = 0; n < H * V; n++) serve(n);
        wait_state("done", 3'd7, 5);
        check("done_flag", done, 1'b1);

        r0 = req_cnt;
        tick(1);
        step = ~step;
        tick(10);
        check("done_noreq", req_cnt - r0, 0);
        check("done_noack", ack, 1'b0);
        check("done_noovr", overrun, 1'b0);
        check("done_hold", state, 3'd7);

        start = 1'b0;
        wait_state("done_idle", 3'd0, 10);
        check("done_clr", done, 1'b0);
        check("hold_pix", pix, 8'hE4);
        check("hold_rc", {row, col}, {9'd3, 7'd79});

        // Arm while a frame is already in progress.
        fval = 1'b1;
        tick(4);
        l0 = load_cnt;
        start = 1'b1;
        wait_state("arm2", 3'd2, 10);
        check("load2", load_cnt - l0, 1);
        check("ovr_arm", overrun, 1'b0);
        tick(1);
        fval = 1'b0;
        tick(6);
        check("skip_fall", state, 3'd2);
        check("skip_cap", cap_en, 1'b1);
        fval = 1'b1;
        wait_state("eof2", 3'd3, 10);
        tick(3);
        fval = 1'b0;
        wait_state("serve2", 3'd4, 10);
        check("cap_off2", cap_en, 1'b0);

        // Abort during FETCH: one strobe, no word, outputs held.
        r0 = req_cnt;
        tick(1);
        step = ~step;
        tick(2);
        start = 1'b0;
        wait_state("abort_idle", 3'd0, 10);
        tick(5);
        check("abort_req", req_cnt - r0, 1);
        check("abort_ack", ack, 1'b0);
        check("abort_pix", pix, 8'hE4);

        // Re-arm, then two step edges back to back.
        start = 1'b1;
        wait_state("arm3", 3'd2, 10);
        fval = 1'b1;
        wait_state("eof3", 3'd3, 10);
        fval = 1'b0;
        wait_state("serve3", 3'd4, 10);
        serve(0);

        a0 = ack;
        a1 = ~a0;
        r0 = req_cnt;
        tick(1);
        step = ~step;
        tick(1);
        step = ~step;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack !== a0) break;
        end
        tick(8);
        check("dbl_ack", ack, a1);
        check("dbl_req", req_cnt - r0, 1);
        check("dbl_ovr", overrun, 1'b1);
        check("dbl_pix", pix, 8'hA6);
        check("dbl_rc", {row, col}, {9'd0, 7'd1});
        check("dbl_state", state, 3'd4);
        serve(2);
        check("ovr_sticky", overrun, 1'b1);

        // Asynchronous reset in the middle of a fetch.
        tick(1);
        step = ~step;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 3'd0);
        check("arst_outs", {cap_en, rd_req, ack, done, overrun}, 5'b0);
        check("arst_pix", {pix, row, col}, 24'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
